// File: rtl/tisc_address_decoder_if.sv
// Bus bundle for the TISC address decoder: address map, master-side Wishbone request
// and response, per-slave strobes/responses and error-cause status.
interface tisc_address_decoder_if #(
    parameter int NUM_SLAVES = 4,
    parameter int WIDTH      = 32
);
    // A request is presented by holding m_cyc_i & m_stb_i until exactly one
    // of m_ack_o / m_err_o pulses; dropping m_cyc_i before that abandons the request.
    logic [NUM_SLAVES*WIDTH-1:0] address_base_i;
    logic [NUM_SLAVES*WIDTH-1:0] address_mask_i;
    logic                        m_cyc_i;
    logic                        m_stb_i;
    logic                        m_we_i;
    logic [WIDTH-1:0]            m_adr_i;
    logic [WIDTH-1:0]            m_dat_i;
    logic [WIDTH/8-1:0]          m_sel_i;
    logic                        m_ack_o;
    logic                        m_err_o;
    logic [WIDTH-1:0]            m_dat_o;
    logic [NUM_SLAVES-1:0]       s_cyc_o;
    logic                        s_stb_o;
    logic                        s_we_o;
    logic [WIDTH-1:0]            s_adr_o;
    logic [WIDTH-1:0]            s_dat_o;
    logic [WIDTH/8-1:0]          s_sel_o;
    logic [NUM_SLAVES-1:0]       s_ack_i;
    logic [NUM_SLAVES-1:0]       s_err_i;
    logic [NUM_SLAVES*WIDTH-1:0] s_dat_i;
    logic                        stat_unmapped_o;
    logic                        stat_timeout_o;

    // Decoder view.
    modport slave (
        input  address_base_i, address_mask_i,
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_err_i, s_dat_i,
        output stat_unmapped_o, stat_timeout_o
    );

    // Environment view: bus master, address map and register-bank slaves.
    modport master (
        output address_base_i, address_mask_i,
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_err_i, s_dat_i,
        input  stat_unmapped_o, stat_timeout_o
    );
endinterface

// File: rtl/tisc_address_decoder.sv
// Routes one Wishbone-classic master request to the lowest-index matching slave of the
// TISC address map; reports unmapped addresses and slave timeouts as bus errors.
module tisc_address_decoder #(
    parameter int NUM_SLAVES     = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tisc_address_decoder_if.slave bus,
    output logic [1:0]           dbg_state_o
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SEL_W = WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      adr_q, adr_d;
    logic [WIDTH-1:0]      dat_q, dat_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_SLAVES-1:0] match_q, match_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] s_cyc_q, s_cyc_d;
    logic                  s_stb_q, s_stb_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  unm_q, unm_d;
    logic                  tmo_q, tmo_d;
    logic [WIDTH-1:0]      rdat_q, rdat_d;

    logic [NUM_SLAVES-1:0] match_now;
    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic                  sel_ack, sel_err;
    logic [WIDTH-1:0]      sel_dat;

    always_comb begin
        match_now = '0;
        for (int n = 0; n < NUM_SLAVES; n++) begin
            match_now[n] = ((bus.m_adr_i ^ bus.address_base_i[n*WIDTH +: WIDTH])
                            & bus.address_mask_i[n*WIDTH +: WIDTH]) == '0;
        end
    end

    // Scanning downward lets the lowest-index match overwrite any higher one.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int n = NUM_SLAVES - 1; n >= 0; n--) begin
            if (match_q[n]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(n);
            end
        end
    end

    assign sel_ack = bus.s_ack_i[idx_q];
    assign sel_err = bus.s_err_i[idx_q];
    assign sel_dat = bus.s_dat_i[int'(idx_q)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        match_d = match_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdat_d  = rdat_q;
        s_cyc_d = '0;
        s_stb_d = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unm_d   = 1'b0;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    adr_d   = bus.m_adr_i;
                    dat_d   = bus.m_dat_i;
                    we_d    = bus.m_we_i;
                    sel_d   = bus.m_sel_i;
                    match_d = match_now;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!bus.m_cyc_i) begin
                    state_d = IDLE;
                end else if (!dec_hit) begin
                    err_d   = 1'b1;
                    unm_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    s_cyc_d = NUM_SLAVES'(1) << dec_idx;
                    s_stb_d = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Error beats a simultaneous ack; an ack beats the timeout.
                if (!bus.m_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_err) begin
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else if (sel_ack) begin
                    ack_d   = 1'b1;
                    rdat_d  = sel_dat;
                    state_d = RESPOND;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    s_cyc_d = s_cyc_q;
                    s_stb_d = 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            match_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            s_cyc_q <= '0;
            s_stb_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            unm_q   <= 1'b0;
            tmo_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            match_q <= match_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            s_cyc_q <= s_cyc_d;
            s_stb_q <= s_stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            unm_q   <= unm_d;
            tmo_q   <= tmo_d;
            rdat_q  <= rdat_d;
        end
    end

    assign bus.m_ack_o         = ack_q;
    assign bus.m_err_o         = err_q;
    assign bus.m_dat_o         = rdat_q;
    assign bus.s_cyc_o         = s_cyc_q;
    assign bus.s_stb_o         = s_stb_q;
    assign bus.s_we_o          = we_q;
    assign bus.s_adr_o         = adr_q;
    assign bus.s_dat_o         = dat_q;
    assign bus.s_sel_o         = sel_q;
    assign bus.stat_unmapped_o = unm_q;
    assign bus.stat_timeout_o  = tmo_q;
    assign dbg_state_o         = state_q;
endmodule

// File: doc/tisc_address_decoder.md
# tisc_address_decoder

Bus-side consumer of the TISC address map: takes the packed per-slave base/mask vectors produced by the address map and a single Wishbone-classic master request, then routes that request to exactly one slave. It returns the slave's response, or an error for unmapped addresses and slave timeouts. It sits between the control-bus master (PCI/I2C bridge) and the register-bank slaves.

## Interface
- NUM_SLAVES, 4, number of base/mask pairs and slave ports (1..16)
- WIDTH, 32, address/data width; fixed per-entry width of the map vectors
- TIMEOUT_CYCLES, 255, maximum cycles a slave strobe is held before error (>=1)
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- address_base_i  in  NUM_SLAVES*WIDTH  packed bases; entry n at [n*WIDTH +: WIDTH]
- address_mask_i  in  NUM_SLAVES*WIDTH  packed masks; mask bit 1 = address bit compared
- m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write enable
- m_adr_i, m_dat_i  in  WIDTH each  master address, write data
- m_sel_i  in  WIDTH/8  byte selects
- m_ack_o, m_err_o  out  1 each  one-cycle response pulses
- m_dat_o  out  WIDTH  read data, valid with m_ack_o
- s_cyc_o  out  NUM_SLAVES  one-hot slave cycle
- s_stb_o, s_we_o  out  1 each  shared slave strobe, write enable
- s_adr_o, s_dat_o  out  WIDTH each  registered address and write data
- s_sel_o  out  WIDTH/8  registered byte selects
- s_ack_i, s_err_i  in  NUM_SLAVES each  per-slave responses
- s_dat_i  in  NUM_SLAVES*WIDTH  packed slave read data
- stat_unmapped_o, stat_timeout_o  out  1 each  error-cause pulses, coincident with m_err_o

## Operation
- FSM states: IDLE, DECODE, ACCESS, RESPOND.
- **IDLE:**
  - On m_cyc_i & m_stb_i, latch adr/dat/we/sel.
  - Register the per-slave match vector: match[n] = ((m_adr_i ^ base[n]) & mask[n]) == 0.
  - Go to DECODE.
- **DECODE:**
  - Lowest-index set match bit wins; latch its index.
  - No match: go to RESPOND with error and unmapped cause.
  - Otherwise go to ACCESS.
- **ACCESS:**
  - Drive s_cyc_o[idx] and s_stb_o; the timeout counter starts at 0.
  - s_err_i[idx]: go to RESPOND with error. Error wins if ack and err arrive together.
  - s_ack_i[idx]: capture s_dat_i[idx] into m_dat_o and go to RESPOND with ack.
  - Neither, and counter == TIMEOUT_CYCLES-1: go to RESPOND with error and timeout cause. An ack in that same cycle wins over the timeout.
  - Otherwise the counter increments.
  - Responses from non-selected slaves are ignored.
- **RESPOND:**
  - Pulse exactly one of m_ack_o or m_err_o, plus the cause pulse on error.
  - Go to IDLE.
  - m_stb_i is ignored in this state; a new request is accepted no earlier than the following IDLE cycle.
- **Abort:** m_cyc_i low in DECODE or ACCESS → deassert all slave strobes, go to IDLE, no response pulse.
- **Map stability:** map inputs are sampled only in IDLE; changes mid-transaction do not affect the latched index.
- **Reset values:** all outputs 0, FSM in IDLE, counter 0. Reset mid-ACCESS drops s_cyc_o/s_stb_o immediately (asynchronous).

## Timing
- Request seen in cycle 0 → DECODE cycle 1 → s_stb_o high from cycle 2.
- Slave acks in cycle k → m_ack_o in cycle k+1. Minimum latency cycle 0 → m_ack_o in cycle 3.
- Unmapped address: m_err_o in cycle 2.
- Timeout: s_stb_o high exactly TIMEOUT_CYCLES cycles (2 .. TIMEOUT_CYCLES+1); m_err_o in cycle TIMEOUT_CYCLES+2.
- m_dat_o holds the captured value until the next captured ack.
- All outputs registered; no combinational path from slave inputs to master outputs.

## Test plan
Bench configuration: NUM_SLAVES=4, TIMEOUT_CYCLES=8. Map: slave0 base 0x00000000 / mask 0xFFFFF000; slave1 0x00001000 / 0xFFFFF000; slave2 0x00010000 / 0xFFFF0000; slave3 0x00001000 / 0xFFFFFF00.

- Read 0x00000004; slave0 acks in the first strobe cycle with 0xDEADBEEF → s_cyc_o=0001 in cycle 2; m_ack_o and m_dat_o=0xDEADBEEF in cycle 3.
- Write 0x00001010 (matches slave1 and slave3) → only s_cyc_o=0010; s_dat_o/s_sel_o equal latched values; m_ack_o follows slave1 ack.
- Read 0x00020000 → no slave strobe; m_err_o=1 and stat_unmapped_o=1 in cycle 2.
- Read 0x00010000 with slave2 silent → s_stb_o high cycles 2..9; m_err_o and stat_timeout_o in cycle 10. Repeat with ack in cycle 9 → m_ack_o, no timeout.
- Slave2 asserts ack and err together → m_err_o only, stat_timeout_o=0. Slave0 acks during a slave2 access → ignored.
- Drop m_cyc_i in cycle 3 of a slave2 access → s_cyc_o=0 in cycle 4, no m_ack_o/m_err_o. Assert rst_i mid-ACCESS → all outputs 0 immediately; next request decodes normally.
